i3c_periph_reset_seq: RTL and testbench

Reset sequencer sitting directly downstream of the I3C core's reset outputs. Consumes the core's peripheral-reset request and escalated-reset indication, and drives a timed active-low reset to the target peripheral. Returns the peripheral_reset_done handshake to the core. Used in the cosim top in place of the Renode-driven done loopback, and in SoC integration.

---
 rtl/i3c_periph_reset_seq.sv | 141 ++++++++++++++
 tb/tb_i3c_periph_reset_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i3c_periph_reset_seq.sv
// rtl/i3c_periph_reset_seq.sv - timed peripheral reset sequencer behind the I3C core reset outputs
`timescale 1ns/1ps

module i3c_periph_reset_seq #(
   parameter int unsigned HoldCycles    = 16,
   parameter int unsigned ReleaseCycles = 4,
   parameter int unsigned CountWidth    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  peripheral_reset_i,
   input  logic                  escalated_reset_i,
   input  logic                  clear_escalation_i,
   output logic                  peripheral_reset_done_o,
   output logic                  periph_rst_no,
   output logic                  sys_reset_req_o,
   output logic                  busy_o,
   output logic [CountWidth-1:0] seq_count_o
);

   // The phase timer only ever holds (cycles - 1) of the longer of the two timed phases.
   localparam int unsigned MaxCycles  = (HoldCycles > ReleaseCycles) ? HoldCycles : ReleaseCycles;
   localparam int unsigned TimerWidth = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [TimerWidth-1:0] HoldLoad    = TimerWidth'(HoldCycles - 1);
   localparam logic [TimerWidth-1:0] ReleaseLoad =
      TimerWidth'((ReleaseCycles > 0) ? (ReleaseCycles - 1) : 0);
   localparam logic [CountWidth-1:0] CountMax = {CountWidth{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_RELEASE,
      ST_DONE,
      ST_ESCALATED
   } state_e;

   state_e                r_state;
   logic [TimerWidth-1:0] r_timer;
   logic                  r_req_q;
   logic                  r_done;
   logic                  r_rst_n;
   logic                  r_sys_req;
   logic                  r_busy;
   logic [CountWidth-1:0] r_seq_count;

   state_e                w_state_nxt;
   logic [TimerWidth-1:0] w_timer_nxt;
   logic                  w_req_rise;
   logic [CountWidth-1:0] w_seq_nxt;

   // Next-state and timer: escalation overrides every state, the timer is reloaded on each entry.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = '0;
      w_req_rise  = peripheral_reset_i & ~r_req_q;
      if (escalated_reset_i) begin
         w_state_nxt = ST_ESCALATED;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_rise) begin
                  w_state_nxt = ST_ASSERT;
                  w_timer_nxt = HoldLoad;
               end
            end
            ST_ASSERT: begin
               if (r_timer == '0) begin
                  if (ReleaseCycles == 0) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_state_nxt = ST_RELEASE;
                     w_timer_nxt = ReleaseLoad;
                  end
               end else begin
                  w_timer_nxt = r_timer - TimerWidth'(1);
               end
            end
            ST_RELEASE: begin
               if (r_timer == '0) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_timer_nxt = r_timer - TimerWidth'(1);
               end
            end
            ST_DONE: begin
               if (!peripheral_reset_i) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_ESCALATED: begin
               if (clear_escalation_i) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Sequence counter: cleared while escalated, bumped once on DONE entry, saturating.
   always_comb begin
      w_seq_nxt = r_seq_count;
      if (w_state_nxt == ST_ESCALATED) begin
         w_seq_nxt = '0;
      end else if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE) && (r_seq_count != CountMax)) begin
         w_seq_nxt = r_seq_count + CountWidth'(1);
      end
   end

   // State register; outputs are registered from the next state so they move with it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_req_q     <= 1'b0;
         r_done      <= 1'b0;
         r_rst_n     <= 1'b0;
         r_sys_req   <= 1'b0;
         r_busy      <= 1'b0;
         r_seq_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_req_q     <= peripheral_reset_i;
         r_done      <= (w_state_nxt == ST_DONE);
         r_rst_n     <= (w_state_nxt != ST_ASSERT) && (w_state_nxt != ST_ESCALATED);
         r_sys_req   <= (w_state_nxt == ST_ESCALATED);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_seq_count <= w_seq_nxt;
      end
   end

   assign peripheral_reset_done_o = r_done;
   assign periph_rst_no           = r_rst_n;
   assign sys_reset_req_o         = r_sys_req;
   assign busy_o                  = r_busy;
   assign seq_count_o             = r_seq_count;

endmodule

// File: tb/tb_i3c_periph_reset_seq.sv
// tb/tb_i3c_periph_reset_seq.sv - scoreboard bench for i3c_periph_reset_seq (release 4 and release 0 builds)
`timescale 1ns/1ps

module tb_i3c_periph_reset_seq;

   localparam int H  = 16;
   localparam int CW = 8;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic peripheral_reset_i = 1'b0;
   logic escalated_reset_i = 1'b0;
   logic clear_escalation_i = 1'b0;

   logic          done_a, rst_n_a, sys_a, busy_a;
   logic [CW-1:0] cnt_a;
   logic          done_b, rst_n_b, sys_b, busy_b;
   logic [CW-1:0] cnt_b;

   int n_cmp = 0;
   int n_fail = 0;

   // model state per build: index 0 -> ReleaseCycles=4, index 1 -> ReleaseCycles=0
   int rel[2] = '{4, 0};
   int m_pos[2];
   int m_cnt[2];
   bit m_esc[2];
   bit m_prev[2];
   bit m_inrst[2];

   logic [23:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   i3c_periph_reset_seq #(.HoldCycles(H), .ReleaseCycles(4), .CountWidth(CW)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .peripheral_reset_i(peripheral_reset_i), .escalated_reset_i(escalated_reset_i),
      .clear_escalation_i(clear_escalation_i),
      .peripheral_reset_done_o(done_a), .periph_rst_no(rst_n_a),
      .sys_reset_req_o(sys_a), .busy_o(busy_a), .seq_count_o(cnt_a)
   );

   i3c_periph_reset_seq #(.HoldCycles(H), .ReleaseCycles(0), .CountWidth(CW)) u_dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .peripheral_reset_i(peripheral_reset_i), .escalated_reset_i(escalated_reset_i),
      .clear_escalation_i(clear_escalation_i),
      .peripheral_reset_done_o(done_b), .periph_rst_no(rst_n_b),
      .sys_reset_req_o(sys_b), .busy_o(busy_b), .seq_count_o(cnt_b)
   );

   // Position-based reference: pos 0 idle, 1..H reset held, H+1..H+R settling, H+R+1 done.
   function automatic logic [11:0] m_out(int i);
      logic d, rn, s, b;
      if (m_inrst[i]) return 12'h000;
      d  = !m_esc[i] && (m_pos[i] == H + rel[i] + 1);
      rn = !(m_esc[i] || (m_pos[i] >= 1 && m_pos[i] <= H));
      s  = m_esc[i];
      b  = m_esc[i] || (m_pos[i] != 0);
      return {d, rn, s, b, 8'(m_cnt[i])};
   endfunction

   task automatic m_edge(input bit req, input bit esc, input bit clr, input bit rst);
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            m_inrst[i] = 1; m_pos[i] = 0; m_esc[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
         end else begin
            m_inrst[i] = 0;
            if (esc) begin
               m_esc[i] = 1; m_pos[i] = 0; m_cnt[i] = 0;
            end else if (m_esc[i]) begin
               if (clr) m_esc[i] = 0;
            end else if (m_pos[i] == 0) begin
               if (req && !m_prev[i]) m_pos[i] = 1;
            end else if (m_pos[i] <= H + rel[i]) begin
               m_pos[i]++;
               if (m_pos[i] == H + rel[i] + 1 && m_cnt[i] < 255) m_cnt[i]++;
            end else if (!req) begin
               m_pos[i] = 0;
            end
            m_prev[i] = req;
         end
      end
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h (done,rst_n,sys,busy,cnt) expected %h", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus: drive mid-cycle, predict the next edge, push the prediction.
   task automatic step(input bit req, input bit esc, input bit clr, input bit rst);
      logic old_rst;
      @(negedge clk_i);
      old_rst = rst_ni;
      peripheral_reset_i = req;
      escalated_reset_i  = esc;
      clear_escalation_i = clr;
      rst_ni             = rst;
      if (old_rst && !rst) begin
         #1;
         chk("async_reset_r4", {done_a, rst_n_a, sys_a, busy_a, cnt_a}, 12'h000);
         chk("async_reset_r0", {done_b, rst_n_b, sys_b, busy_b, cnt_b}, 12'h000);
      end
      m_edge(req, esc, clr, rst);
      exp_q.push_back({m_out(0), m_out(1)});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 1);
   endtask

   // Monitor: compares the DUT outputs after every active edge against the queued prediction.
   initial begin
      logic [23:0] e;
      forever begin
         @(posedge clk_i);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs_r4", {done_a, rst_n_a, sys_a, busy_a, cnt_a}, e[23:12]);
            chk("outputs_r0", {done_b, rst_n_b, sys_b, busy_b, cnt_b}, e[11:0]);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit r_req;
      int esc_left;
      int rst_left;
      bit esc;

      for (int i = 0; i < 2; i++) begin
         m_inrst[i] = 1; m_pos[i] = 0; m_esc[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
      end

      // reset held, then released; request at edge 10 held long (plan 1) and dropped (plan 2)
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
      idle(6);
      for (int k = 0; k < 30; k++) step(1, 0, 0, 1);
      idle(5);
      for (int k = 0; k < 30; k++) step(1, 0, 0, 1);
      idle(4);

      // single-cycle request runs the full sequence (plan 3)
      step(1, 0, 0, 1);
      idle(30);

      // escalation during ASSERT, ignored clear, then a real clear (plan 4)
      step(1, 0, 0, 1);
      idle(4);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 1);
      step(0, 1, 1, 1);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 1);
      idle(3);
      step(0, 0, 1, 1);
      idle(3);

      // escalation and request on the same edge in IDLE
      step(1, 1, 0, 1);
      step(1, 0, 1, 1);
      idle(25);

      // request left high after leaving escalation: no new sequence without a rising edge
      for (int k = 0; k < 3; k++) step(1, 1, 0, 1);
      step(1, 0, 1, 1);
      for (int k = 0; k < 8; k++) step(1, 0, 0, 1);
      idle(25);

      // reset mid-ASSERT (plan 6)
      step(1, 0, 0, 1);
      idle(9);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
      idle(30);

      // drive the sequence counter into saturation
      for (int s = 0; s < 258; s++) begin
         step(1, 0, 0, 1);
         idle(22);
      end

      // randomized traffic
      r_req = 0;
      esc_left = 0;
      rst_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 11) == 0) r_req = !r_req;
         if (esc_left > 0) esc_left--;
         else if ($urandom_range(0, 299) == 0) esc_left = $urandom_range(1, 6);
         esc = (esc_left > 0);
         if (rst_left > 0) rst_left--;
         else if ($urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 3);
         step(r_req, esc, ($urandom_range(0, 9) == 0), (rst_left == 0));
      end

      idle(3);
      @(posedge clk_i);
      #5;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
